// File: rtl/spart_pkg.sv
// Shared constants, bus payload type and lookup helpers for the SPART bus-master driver.
package spart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned BR_W   = 2;

   localparam logic [ADDR_W-1:0] ADDR_BUF  = 2'b00;
   localparam logic [ADDR_W-1:0] ADDR_STAT = 2'b01;
   localparam logic [ADDR_W-1:0] ADDR_DBL  = 2'b10;
   localparam logic [ADDR_W-1:0] ADDR_DBH  = 2'b11;

   typedef enum logic [2:0] {
      INIT_LO,
      INIT_HI,
      IDLE,
      READ,
      WAIT_TBR,
      WRITE
   } drv_state_t;

   // One registered bus cycle as presented to the SPART.
   typedef struct packed {
      logic              iocs;
      logic              iorw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } bus_req_t;

   localparam bus_req_t BUS_IDLE = '{
      iocs: 1'b0,
      iorw: 1'b1,
      addr: ADDR_STAT,
      data: DATA_W'(0)
   };

   // Baud divisors for a 50 MHz clock with 16x oversampling.
   function automatic logic [DIV_W-1:0] div_for(input logic [BR_W-1:0] br_cfg);
      logic [DIV_W-1:0] div;
      case (br_cfg)
         2'b00:   div = 16'h028A;
         2'b01:   div = 16'h0145;
         2'b10:   div = 16'h00A2;
         default: div = 16'h0050;
      endcase
      return div;
   endfunction

   function automatic logic [DATA_W-1:0] swap_case(input logic [DATA_W-1:0] b);
      logic is_alpha;
      is_alpha = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
      return is_alpha ? (b ^ 8'h20) : b;
   endfunction

endpackage

// File: rtl/spart_driver.sv
// Bus master that programs the SPART baud divisor after reset, then echoes every received byte.
module spart_driver
   import spart_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter bit          SWAP_CASE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BR_W-1:0]   br_cfg,
   input  logic              rda,
   input  logic              tbr,
   output logic              iocs,
   output logic              iorw,
   output logic [ADDR_W-1:0] ioaddr,
   inout  wire  [DATA_W-1:0] databus
);

   // The divisor table in the package is only valid for this clock.
   if (CLK_HZ != 32'd50000000) begin : g_clk_guard
      $error("spart_driver: divisor table assumes a 50 MHz clock");
   end

   drv_state_t        r_state;
   drv_state_t        w_state_nxt;
   bus_req_t          r_req;
   bus_req_t          w_req_nxt;
   logic [BR_W-1:0]   r_br_cfg_q;
   logic [DATA_W-1:0] r_rx_byte;
   logic              w_br_latch;
   logic              w_capture;
   logic [DIV_W-1:0]  w_div_new;
   logic [DIV_W-1:0]  w_div_q;
   logic [DATA_W-1:0] w_tx_byte;

   assign w_div_new = div_for(br_cfg);
   assign w_div_q   = div_for(r_br_cfg_q);
   assign w_tx_byte = SWAP_CASE ? swap_case(r_rx_byte) : r_rx_byte;

   // State and bus-cycle registers; outputs for a state are issued on the edge leaving it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= INIT_LO;
         r_req   <= BUS_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_br_cfg_q <= br_cfg;
         r_rx_byte  <= DATA_W'(0);
      end else begin
         if (w_br_latch) begin
            r_br_cfg_q <= br_cfg;
         end
         if (w_capture) begin
            r_rx_byte <= databus;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = BUS_IDLE;
      w_br_latch  = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         INIT_LO: begin
            w_req_nxt   = '{iocs: 1'b1, iorw: 1'b0, addr: ADDR_DBL, data: w_div_new[7:0]};
            w_br_latch  = 1'b1;
            w_state_nxt = INIT_HI;
         end
         INIT_HI: begin
            w_req_nxt   = '{iocs: 1'b1, iorw: 1'b0, addr: ADDR_DBH, data: w_div_q[15:8]};
            w_state_nxt = IDLE;
         end
         IDLE: begin
            // A baud change wins over pending receive data.
            if (br_cfg != r_br_cfg_q) begin
               w_state_nxt = INIT_LO;
            end else if (rda) begin
               w_req_nxt   = '{iocs: 1'b1, iorw: 1'b1, addr: ADDR_BUF, data: DATA_W'(0)};
               w_state_nxt = READ;
            end
         end
         READ: begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT_TBR;
         end
         WAIT_TBR: begin
            if (tbr) begin
               w_req_nxt   = '{iocs: 1'b1, iorw: 1'b0, addr: ADDR_BUF, data: w_tx_byte};
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = INIT_LO;
         end
      endcase
   end

   assign iocs   = r_req.iocs;
   assign iorw   = r_req.iorw;
   assign ioaddr = r_req.addr;

   // Drive the shared bus only during a write access.
   assign databus = (r_req.iocs && !r_req.iorw) ? r_req.data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a small SPART model keeps the bus and supplies receive bytes.
module tb_spart_driver;

   logic       clk;
   logic       rst;
   logic [1:0] br_cfg;
   logic       rda;
   logic       tbr;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;

   logic [7:0] m_rx;
   int         n_pass;
   int         n_total;

   typedef struct packed {
      logic [7:0] rx;
      logic [7:0] tbr_wait;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [0:7];

   spart_driver dut (
      .clk     (clk),
      .rst     (rst),
      .br_cfg  (br_cfg),
      .rda     (rda),
      .tbr     (tbr),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus)
   );

   // SPART side: returns m_rx on reads, holds the bus low when nobody should be driving.
   assign databus = (iocs && !iorw) ? 8'hzz : ((iocs && iorw) ? m_rx : 8'h00);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (iocs,iorw,ioaddr,data)", name, got, exp);
      end
   endtask

   task automatic chk_bus(input string name, input logic c, input logic rw,
                          input logic [1:0] a, input logic [7:0] d);
      chk(name, {iocs, iorw, ioaddr, databus}, {c, rw, a, d});
   endtask

   // Advance one cycle and verify the driver left the bus alone unless writing.
   task automatic step();
      logic [7:0] keep;
      @(negedge clk);
      if (!(iocs && !iorw)) begin
         keep = (iocs && iorw) ? m_rx : 8'h00;
         chk("bus_contention", {4'h0, databus}, {4'h0, keep});
      end
   endtask

   task automatic echo(input logic [7:0] rx, input int unsigned wait_n, input logic [7:0] exp);
      m_rx = rx;
      rda  = 1'b1;
      tbr  = (wait_n == 0);
      step(); chk_bus("echo_read", 1'b1, 1'b1, 2'b00, rx);
      rda = 1'b0;
      step(); chk_bus("echo_gap", 1'b0, 1'b1, 2'b01, 8'h00);
      for (int k = 0; k < int'(wait_n); k++) begin
         step(); chk_bus("wait_tbr_hold", 1'b0, 1'b1, 2'b01, 8'h00);
      end
      tbr = 1'b1;
      step(); chk_bus("echo_write", 1'b1, 1'b0, 2'b00, exp);
      tbr = 1'b0;
      step(); chk_bus("echo_idle", 1'b0, 1'b1, 2'b01, 8'h00);
   endtask

   initial begin
      rst     = 1'b0;
      br_cfg  = 2'b01;
      rda     = 1'b0;
      tbr     = 1'b0;
      m_rx    = 8'h00;
      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{rx: 8'h41, tbr_wait: 8'd0,   exp: 8'h41};
      vecs[1] = '{rx: 8'h00, tbr_wait: 8'd0,   exp: 8'h00};
      vecs[2] = '{rx: 8'hFF, tbr_wait: 8'd1,   exp: 8'hFF};
      vecs[3] = '{rx: 8'h7A, tbr_wait: 8'd3,   exp: 8'h7A};
      vecs[4] = '{rx: 8'h61, tbr_wait: 8'd0,   exp: 8'h61};
      vecs[5] = '{rx: 8'h80, tbr_wait: 8'd2,   exp: 8'h80};
      vecs[6] = '{rx: 8'h5A, tbr_wait: 8'd0,   exp: 8'h5A};
      vecs[7] = '{rx: 8'h41, tbr_wait: 8'd100, exp: 8'h41};

      // Reset and divisor programming for 9600 baud.
      @(negedge clk);
      step(); chk_bus("reset_state", 1'b0, 1'b1, 2'b01, 8'h00);
      rst = 1'b1;
      step(); chk_bus("init_lo_9600", 1'b1, 1'b0, 2'b10, 8'h45);
      step(); chk_bus("init_hi_9600", 1'b1, 1'b0, 2'b11, 8'h01);
      step(); chk_bus("idle_after_init", 1'b0, 1'b1, 2'b01, 8'h00);

      for (int i = 0; i < 8; i++) begin
         echo(vecs[i].rx, int'(vecs[i].tbr_wait), vecs[i].exp);
      end

      // rda held high: a second read follows the echo without de-duplication.
      m_rx = 8'h33; rda = 1'b1; tbr = 1'b1;
      step(); chk_bus("hold_read1", 1'b1, 1'b1, 2'b00, 8'h33);
      step(); chk_bus("hold_gap1", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("hold_write1", 1'b1, 1'b0, 2'b00, 8'h33);
      m_rx = 8'h34;
      step(); chk_bus("hold_idle1", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("hold_read2", 1'b1, 1'b1, 2'b00, 8'h34);
      rda = 1'b0;
      step(); chk_bus("hold_gap2", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("hold_write2", 1'b1, 1'b0, 2'b00, 8'h34);
      tbr = 1'b0;
      step(); chk_bus("hold_idle2", 1'b0, 1'b1, 2'b01, 8'h00);

      // Baud change during WAIT_TBR: echo completes, then re-init to 38400.
      m_rx = 8'h55; rda = 1'b1;
      step(); chk_bus("brchg_read", 1'b1, 1'b1, 2'b00, 8'h55);
      rda = 1'b0;
      step(); chk_bus("brchg_gap", 1'b0, 1'b1, 2'b01, 8'h00);
      br_cfg = 2'b11;
      step(); chk_bus("brchg_wait1", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("brchg_wait2", 1'b0, 1'b1, 2'b01, 8'h00);
      tbr = 1'b1;
      step(); chk_bus("brchg_write", 1'b1, 1'b0, 2'b00, 8'h55);
      tbr = 1'b0;
      step(); chk_bus("brchg_idle", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("brchg_init_wait", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("init_lo_38400", 1'b1, 1'b0, 2'b10, 8'h50);
      step(); chk_bus("init_hi_38400", 1'b1, 1'b0, 2'b11, 8'h00);
      step(); chk_bus("idle_after_reinit", 1'b0, 1'b1, 2'b01, 8'h00);

      // br_cfg glitch that returns to its old value before IDLE: no re-init.
      m_rx = 8'h10; rda = 1'b1; tbr = 1'b1;
      step(); chk_bus("glitch_read", 1'b1, 1'b1, 2'b00, 8'h10);
      rda = 1'b0; br_cfg = 2'b00;
      step(); chk_bus("glitch_gap", 1'b0, 1'b1, 2'b01, 8'h00);
      br_cfg = 2'b11;
      step(); chk_bus("glitch_write", 1'b1, 1'b0, 2'b00, 8'h10);
      tbr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(); chk_bus("glitch_no_reinit", 1'b0, 1'b1, 2'b01, 8'h00);
      end

      // Reset during a WRITE access: bus released next cycle, init restarts with new br_cfg.
      m_rx = 8'h99; rda = 1'b1; tbr = 1'b1;
      step(); chk_bus("rst_read", 1'b1, 1'b1, 2'b00, 8'h99);
      rda = 1'b0;
      step(); chk_bus("rst_gap", 1'b0, 1'b1, 2'b01, 8'h00);
      step(); chk_bus("rst_write", 1'b1, 1'b0, 2'b00, 8'h99);
      rst = 1'b0; br_cfg = 2'b01; tbr = 1'b0;
      step(); chk_bus("rst_release_bus", 1'b0, 1'b1, 2'b01, 8'h00);
      rst = 1'b1;
      step(); chk_bus("rst_init_lo", 1'b1, 1'b0, 2'b10, 8'h45);
      step(); chk_bus("rst_init_hi", 1'b1, 1'b0, 2'b11, 8'h01);
      step(); chk_bus("rst_idle", 1'b0, 1'b1, 2'b01, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
